// File: rtl/dm_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes and the clear/run FSM states.
package dm_pkg;

   localparam logic [1:0] SIZE_WORD = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_BYTE = 2'd2;

   typedef enum logic {ST_CLEAR, ST_RUN} state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering for the data memory.
// On the store path it merges right-aligned store data into the old word; on the load path it
// selects the addressed byte or half and extends it.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] old_word,
   input  logic        load_unsigned,
   output logic [31:0] merged_word,
   output logic [3:0]  lane_en,
   output logic [31:0] load_data
);

   logic [31:0] wdata_rep;
   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      lane_en   = 4'b0000;
      wdata_rep = 32'd0;
      case (size)
         SIZE_WORD: begin
            lane_en   = 4'b1111;
            wdata_rep = wdata;
         end
         SIZE_HALF: begin
            lane_en   = offset[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
         end
         SIZE_BYTE: begin
            lane_en   = 4'b0001 << offset;
            wdata_rep = {4{wdata[7:0]}};
         end
         default: ;
      endcase

      merged_word = old_word;
      for (int k = 0; k < 4; k++) begin
         if (lane_en[k]) merged_word[8*k +: 8] = wdata_rep[8*k +: 8];
      end
   end

   always_comb begin
      shifted   = old_word >> {offset, 3'b000};
      byte_sel  = shifted[7:0];
      half_sel  = offset[1] ? old_word[31:16] : old_word[15:0];
      load_data = 32'd0;
      case (size)
         SIZE_WORD: load_data = old_word;
         SIZE_HALF: load_data = {{16{~load_unsigned & half_sel[15]}}, half_sel};
         SIZE_BYTE: load_data = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
         default:   load_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/dm_bytelane.sv
// MEM-stage data memory: per-lane stores, extended sub-word loads, a one-cycle registered
// response with AdEL/AdES reporting, and a hardware clear sweep after reset.
module dm_bytelane
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_exc_ld,
   output logic        resp_exc_st
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
   logic [31:0]      mem_q [DEPTH_WORDS];

   logic             resp_valid_q, resp_valid_d;
   logic [31:0]      resp_rdata_q, resp_rdata_d;
   logic             resp_exc_ld_q, resp_exc_ld_d;
   logic             resp_exc_st_q, resp_exc_st_d;

   logic [IDX_W-1:0] idx;
   logic [31:0]      old_word;
   logic [31:0]      merged_word;
   logic [31:0]      load_data;
   logic [3:0]       lane_en;
   logic             accept;
   logic             out_of_range;
   logic             fault;
   logic             store_we;
   logic             clear_we;

   assign idx          = req_addr[IDX_W+1:2];
   assign old_word     = mem_q[idx];
   assign ready        = (state_q == ST_RUN);
   assign accept       = req_valid && ready;
   assign out_of_range = (req_addr >> (IDX_W + 2)) != 32'd0;
   assign fault        = (req_size == 2'd3)
                       | ((req_size == SIZE_HALF) & req_addr[0])
                       | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00))
                       | out_of_range;
   assign store_we     = accept & req_we & ~fault;

   dm_lane_align u_lane_align (
      .size          (req_size),
      .offset        (req_addr[1:0]),
      .wdata         (req_wdata),
      .old_word      (old_word),
      .load_unsigned (req_unsigned),
      .merged_word   (merged_word),
      .lane_en       (lane_en),
      .load_data     (load_data)
   );

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      clear_we  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clear_we = 1'b1;
            if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) state_d = ST_RUN;
            else                                        clr_idx_d = clr_idx_q + 1'b1;
         end
         ST_RUN: ;
         default: state_d = ST_CLEAR;
      endcase
   end

   always_comb begin
      resp_valid_d  = accept;
      resp_rdata_d  = (accept && !req_we && !fault) ? load_data : 32'd0;
      resp_exc_ld_d = accept & fault & ~req_we;
      resp_exc_st_d = accept & fault & req_we;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_CLEAR;
         clr_idx_q     <= '0;
         resp_valid_q  <= 1'b0;
         resp_rdata_q  <= 32'd0;
         resp_exc_ld_q <= 1'b0;
         resp_exc_st_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         clr_idx_q     <= clr_idx_d;
         resp_valid_q  <= resp_valid_d;
         resp_rdata_q  <= resp_rdata_d;
         resp_exc_ld_q <= resp_exc_ld_d;
         resp_exc_st_q <= resp_exc_st_d;
      end
   end

   // Array has no reset of its own; the clear sweep zeroes it after every reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (clear_we) begin
            mem_q[clr_idx_q] <= 32'd0;
         end else if (store_we) begin
            for (int k = 0; k < 4; k++) begin
               if (lane_en[k]) mem_q[idx][8*k +: 8] <= merged_word[8*k +: 8];
            end
         end
      end
   end

   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_exc_ld = resp_exc_ld_q;
   assign resp_exc_st = resp_exc_st_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && store_we) begin
         $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged_word);
      end
   end
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
// Directed bench for dm_bytelane (16 words): clear sequence, lane stores, extended loads,
// faults, back-to-back store/load and reset during RUN.
module tb_dm_bytelane;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_exc_ld;
   logic        resp_exc_st;

   int checks = 0;
   int errors = 0;

   dm_bytelane #(.DEPTH_WORDS(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_pc       (req_pc),
      .ready        (ready),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_exc_ld  (resp_exc_ld),
      .resp_exc_st  (resp_exc_st)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_ld;
      logic        exp_st;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic we, logic [1:0] size, logic uns,
                               logic [31:0] addr, logic [31:0] wdata, logic [31:0] exp_rdata,
                               logic exp_ld, logic exp_st);
      vec_t v;
      v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_ld = exp_ld; v.exp_st = exp_st;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_pc       = 32'h0040_0000 + addr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      drive(v.we, v.size, v.uns, v.addr, v.wdata);
      step();
      req_valid = 1'b0;
      chk({v.name, "/valid"}, {31'd0, resp_valid}, 32'd1);
      chk({v.name, "/rdata"}, resp_rdata, v.exp_rdata);
      chk({v.name, "/exc_ld"}, {31'd0, resp_exc_ld}, {31'd0, v.exp_ld});
      chk({v.name, "/exc_st"}, {31'd0, resp_exc_st}, {31'd0, v.exp_st});
   endtask

   // Counts 16 clear edges after reset release; ready must stay low until the last one.
   task automatic clear_sweep(input string tag);
      for (int i = 1; i <= 16; i++) begin
         step();
         chk({tag, "/clr_valid"}, {31'd0, resp_valid}, 32'd0);
         chk({tag, "/clr_ready"}, {31'd0, ready}, (i == 16) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
      req_valid = 1'b0;

      vecs.push_back(mk("lw0_cleared",   0, 2'd0, 0, 32'h00, 32'h0,        32'h0,        0, 0));
      vecs.push_back(mk("lw3c_cleared",  0, 2'd0, 0, 32'h3C, 32'h0,        32'h0,        0, 0));
      vecs.push_back(mk("sw8",           1, 2'd0, 0, 32'h08, 32'h11223344, 32'h0,        0, 0));
      vecs.push_back(mk("sbA",           1, 2'd2, 0, 32'h0A, 32'hFFFFFFAA, 32'h0,        0, 0));
      vecs.push_back(mk("lw8_merge",     0, 2'd0, 0, 32'h08, 32'h0,        32'h11AA3344, 0, 0));
      vecs.push_back(mk("lw8_uns",       0, 2'd0, 1, 32'h08, 32'h0,        32'h11AA3344, 0, 0));
      vecs.push_back(mk("sw4",           1, 2'd0, 0, 32'h04, 32'h8000F080, 32'h0,        0, 0));
      vecs.push_back(mk("lb4",           0, 2'd2, 0, 32'h04, 32'h0,        32'hFFFFFF80, 0, 0));
      vecs.push_back(mk("lbu4",          0, 2'd2, 1, 32'h04, 32'h0,        32'h00000080, 0, 0));
      vecs.push_back(mk("lh6",           0, 2'd1, 0, 32'h06, 32'h0,        32'hFFFF8000, 0, 0));
      vecs.push_back(mk("lhu4",          0, 2'd1, 1, 32'h04, 32'h0,        32'h0000F080, 0, 0));
      vecs.push_back(mk("lhu6",          0, 2'd1, 1, 32'h06, 32'h0,        32'h00008000, 0, 0));
      vecs.push_back(mk("lb5",           0, 2'd2, 0, 32'h05, 32'h0,        32'hFFFFFFF0, 0, 0));
      vecs.push_back(mk("lbu7",          0, 2'd2, 1, 32'h07, 32'h0,        32'h00000080, 0, 0));
      vecs.push_back(mk("lh4",           0, 2'd1, 0, 32'h04, 32'h0,        32'hFFFFF080, 0, 0));
      vecs.push_back(mk("sw0",           1, 2'd0, 0, 32'h00, 32'h01020304, 32'h0,        0, 0));
      vecs.push_back(mk("sh3_fault",     1, 2'd1, 0, 32'h03, 32'h00005566, 32'h0,        0, 1));
      vecs.push_back(mk("lw0_unchanged", 0, 2'd0, 0, 32'h00, 32'h0,        32'h01020304, 0, 0));
      vecs.push_back(mk("sh2",           1, 2'd1, 0, 32'h02, 32'h1234BEEF, 32'h0,        0, 0));
      vecs.push_back(mk("sb1",           1, 2'd2, 0, 32'h01, 32'hFFFFFF77, 32'h0,        0, 0));
      vecs.push_back(mk("lw0_lanes",     0, 2'd0, 0, 32'h00, 32'h0,        32'hBEEF7704, 0, 0));
      vecs.push_back(mk("lw40_range",    0, 2'd0, 0, 32'h40, 32'h0,        32'h0,        1, 0));
      vecs.push_back(mk("lw2_misalign",  0, 2'd0, 0, 32'h02, 32'h0,        32'h0,        1, 0));
      vecs.push_back(mk("lh1_misalign",  0, 2'd1, 0, 32'h01, 32'h0,        32'h0,        1, 0));
      vecs.push_back(mk("ld_size3",      0, 2'd3, 0, 32'h00, 32'h0,        32'h0,        1, 0));
      vecs.push_back(mk("st_size3",      1, 2'd3, 0, 32'h00, 32'hFFFFFFFF, 32'h0,        0, 1));
      vecs.push_back(mk("sw_hi_range",   1, 2'd0, 0, 32'h80000000, 32'h55555555, 32'h0,  0, 1));
      vecs.push_back(mk("lw0_after_flt", 0, 2'd0, 0, 32'h00, 32'h0,        32'hBEEF7704, 0, 0));
      vecs.push_back(mk("lbu3",          0, 2'd2, 1, 32'h03, 32'h0,        32'h000000BE, 0, 0));
      vecs.push_back(mk("lb2",           0, 2'd2, 0, 32'h02, 32'h0,        32'hFFFFFFEF, 0, 0));

      // Reset and clear sweep
      step();
      step();
      chk("rst/ready", {31'd0, ready}, 32'd0);
      chk("rst/valid", {31'd0, resp_valid}, 32'd0);
      chk("rst/rdata", resp_rdata, 32'd0);
      chk("rst/exc", {30'd0, resp_exc_ld, resp_exc_st}, 32'd0);
      reset = 1'b0;
      chk("rel/ready", {31'd0, ready}, 32'd0);
      clear_sweep("init");

      foreach (vecs[i]) run_vec(vecs[i]);

      step();
      chk("idle/valid", {31'd0, resp_valid}, 32'd0);

      // Back-to-back store then load to the same word
      drive(1'b1, 2'd0, 1'b0, 32'h00, 32'hDEADBEEF);
      step();
      chk("b2b/st_valid", {31'd0, resp_valid}, 32'd1);
      chk("b2b/st_rdata", resp_rdata, 32'd0);
      drive(1'b0, 2'd0, 1'b0, 32'h00, 32'h0);
      step();
      req_valid = 1'b0;
      chk("b2b/ld_valid", {31'd0, resp_valid}, 32'd1);
      chk("b2b/ld_rdata", resp_rdata, 32'hDEADBEEF);
      step();
      chk("b2b/after_valid", {31'd0, resp_valid}, 32'd0);

      // Reset while a load response is in flight; request kept asserted through the clear
      drive(1'b0, 2'd0, 1'b0, 32'h08, 32'h0);
      step();
      chk("mid/pre_valid", {31'd0, resp_valid}, 32'd1);
      chk("mid/pre_rdata", resp_rdata, 32'h11AA3344);
      reset = 1'b1;
      step();
      chk("mid/rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("mid/rst_ready", {31'd0, ready}, 32'd0);
      chk("mid/rst_rdata", resp_rdata, 32'd0);
      reset = 1'b0;
      clear_sweep("mid");
      req_valid = 1'b0;
      run_vec(mk("mid/lw8_cleared", 0, 2'd0, 0, 32'h08, 32'h0, 32'h0, 0, 0));
      run_vec(mk("mid/lw0_cleared", 0, 2'd0, 0, 32'h00, 32'h0, 32'h0, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
